// File: rtl/select_in_dispatch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// select_in_dispatch: steers an indexed input stream to one of funnelWidth
// lanes, each with a one-entry holding register.  Rev 1.0
// ---------------------------------------------------------------------------
module select_in_dispatch #(
  parameter int funnelWidth = 4,
  parameter int width       = 32
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         in__ENA,
  input  logic [7:0]                   in_rindex,
  input  logic [width-1:0]             in_v,
  output logic                         in__RDY,
  output logic [funnelWidth-1:0]       out__ENA,
  output logic [funnelWidth*width-1:0] out_v,
  input  logic [funnelWidth-1:0]       out__RDY,
  output logic [15:0]                  dropCount,
  output logic                         dropSticky
);

  // Nine bits so that funnelWidth = 256 is representable; all index bits compare.
  localparam logic [8:0] C_LANES = 9'(funnelWidth);

  logic [funnelWidth-1:0]            full_q, full_d;
  logic [funnelWidth-1:0][width-1:0] data_q, data_d;
  logic [15:0]                       drop_count_q, drop_count_d;
  logic                              drop_sticky_q, drop_sticky_d;

  logic                   in_range;
  logic [funnelWidth-1:0] lane_sel;
  logic                   rdy;
  logic                   accept;

  always_comb begin
    in_range = ({1'b0, in_rindex} < C_LANES);
    lane_sel = '0;
    for (int i = 0; i < funnelWidth; i++) begin
      lane_sel[i] = in_range && (in_rindex == 8'(i));
    end

    // A full lane can still take a beat when it drains on the same edge.
    rdy    = !in_range || (|(lane_sel & (~full_q | out__RDY)));
    accept = in__ENA && rdy;

    full_d = (full_q & ~out__RDY) | (accept ? lane_sel : '0);

    data_d = data_q;
    for (int i = 0; i < funnelWidth; i++) begin
      if (accept && lane_sel[i]) begin
        data_d[i] = in_v;
      end
    end

    drop_count_d  = drop_count_q;
    drop_sticky_d = drop_sticky_q;
    if (accept && !in_range) begin
      drop_sticky_d = 1'b1;
      if (drop_count_q != 16'hFFFF) begin
        drop_count_d = drop_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      full_q        <= '0;
      drop_count_q  <= '0;
      drop_sticky_q <= 1'b0;
    end else begin
      full_q        <= full_d;
      drop_count_q  <= drop_count_d;
      drop_sticky_q <= drop_sticky_d;
    end
  end

  // Payload storage carries no reset; validity lives entirely in full_q.
  always_ff @(posedge CLK) begin
    data_q <= data_d;
  end

  assign in__RDY    = rdy;
  assign out__ENA   = full_q;
  assign out_v      = data_q;
  assign dropCount  = drop_count_q;
  assign dropSticky = drop_sticky_q;

endmodule
`default_nettype wire

// File: doc/select_in_dispatch.md
# select_in_dispatch

Fan-out steering block, the receive-side counterpart of the round-robin SelectOut funnel. It accepts one indexed stream (`rindex`, `v`), the same shape the funnel's consumer emits as `heard`, and routes each beat to one of `funnelWidth` output lanes. Each lane has a one-entry holding register, so a stalled lane never blocks traffic to other lanes. It sits between a P2M request pipe and a bank of per-lane consumers (for example Fifo1Base instances).

## Interface

Parameters:
- `funnelWidth`, 4: number of output lanes, 1..256.
- `width`, 32: data width in bits.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `in__ENA`  in  1  input beat valid.
- `in$rindex`  in  8  destination lane index.
- `in$v`  in  `width`  input data.
- `in__RDY`  out  1  input can accept a beat this cycle.
- `out__ENA`  out  `funnelWidth`  per-lane data valid.
- `out$v`  out  `funnelWidth*width`  per-lane data; lane i occupies bits `[i*width +: width]`.
- `out__RDY`  in  `funnelWidth`  per-lane consumer ready.
- `dropCount`  out  16  count of beats dropped for an out-of-range index; saturating.
- `dropSticky`  out  1  set on the first drop; cleared only by reset.

## Operation

- Per-lane state: `full[i]` (1 bit) and `data[i]` (`width` bits).
- Output lane i:
  - `out__ENA[i] = full[i]`.
  - `out$v` slice i = `data[i]`.
  - A lane transfer occurs when `full[i] && out__RDY[i]`.
- Input readiness, with `r = in$rindex`:
  - If `r < funnelWidth`: `in__RDY = !full[r] || out__RDY[r]`.
  - If `r >= funnelWidth`: `in__RDY = 1`.
  - `in__RDY` depends combinationally on `in$rindex` and `out__RDY`.
- Input accept occurs when `in__ENA && in__RDY`.
  - In-range accept: `data[r] <= in$v` and `full[r] <= 1`.
  - Out-of-range accept: the beat is discarded, `dropCount` increments (saturating at 16'hFFFF), and `dropSticky <= 1`.
- Lane update per cycle, evaluated independently for each i:
  - Accept to i, with or without a transfer from i: `full` stays or becomes 1, and `data` takes the new value.
  - Transfer from i with no accept to i: `full[i] <= 0`; `data` is held (don't-care).
  - Neither: hold.
- `in__ENA` while `in__RDY = 0` is a protocol violation by the source. No state change is allowed and no drop is counted.
- No ordering guarantee holds across lanes. Within a lane, beats leave in acceptance order.

## Timing

- Reset (async assert, `nRST = 0`):
  - All `full` = 0, `out__ENA` = 0, `dropCount` = 0, `dropSticky` = 0.
  - `data` is not reset.
  - `in__RDY` evaluates to 1 for any index while in reset and after reset.
- Reset deassertion is synchronised externally. The first accept is legal on the first rising edge with `nRST = 1`.
- Reset mid-operation: buffered beats are lost and no `out__ENA` glitch is produced after assertion.
- Latency: a beat accepted at edge N presents `out__ENA[r] = 1` in the cycle following edge N, with one register stage. There is no combinational `in$v` to `out$v` path.
- Throughput: one beat per cycle overall. Per lane, one beat per cycle while that lane's `out__RDY` stays high, via simultaneous drain and refill.
- Full lane with `out__RDY[r] = 0`: `in__RDY = 0` for that index only. Beats to other lanes are unaffected.
- `dropCount` saturation: stays at 16'hFFFF, and `dropSticky` stays at 1.
- Index boundary: `rindex = funnelWidth-1` is valid; `rindex = funnelWidth` is dropped. All 8 index bits are compared, so no truncation occurs.

## Test plan

- **Basic steer.** Reset, then send (rindex=2, v=32'hDEADBEEF) with all `out__RDY = 1` -> next cycle `out__ENA = 4'b0100` and lane 2 `out$v = 32'hDEADBEEF` for one cycle, then `out__ENA = 0`.
- **Back-pressure isolation.** Set `out__RDY[1] = 0`, then send v=1 and v=2 to lane 1 -> the first is accepted, `in__RDY = 0` for rindex=1 with lane 1 holding 1. Send v=3 to lane 0 -> accepted, and `out__ENA[0]` is asserted the next cycle. Raise `out__RDY[1]` -> lane 1 delivers 1, then 2.
- **Drain-and-refill.** Lane 3 stays full with `out__RDY[3] = 1`, and beats 10, 11, 12 are presented on consecutive cycles -> `in__RDY` stays 1 and lane 3 emits 10, 11, 12 on consecutive cycles with no bubble.
- **Out-of-range drop.** Send rindex=4 and rindex=255 (funnelWidth=4) -> both accepted, `dropCount = 2`, `dropSticky = 1`, `out__ENA` remains 0.
- **Saturation.** Force 65537 drops -> `dropCount = 16'hFFFF`.
- **Async reset mid-flight.** All lanes full and stalled; assert `nRST` between edges -> `out__ENA` = 0 and `dropCount` = 0 immediately. After release, (rindex=0, v=5) is delivered normally.
